// File: rtl/alu_control_seq_if.sv
// Handshake bundle between the ID-stage control unit (master) and the
// registered ALU control sequencer (slave).
interface alu_control_seq_if #(
   parameter int OP_SEL_WIDTH = 4
);
   logic                    valid_i;
   logic [2:0]              alu_op_i;
   logic [5:0]              alu_function_i;
   logic                    ready_o;
   logic [OP_SEL_WIDTH-1:0] alu_operation_o;
   logic                    op_valid_o;
   logic                    mc_start_o;
   logic                    stall_o;
   logic                    illegal_o;

   modport master (
      output valid_i, alu_op_i, alu_function_i,
      input  ready_o, alu_operation_o, op_valid_o, mc_start_o, stall_o, illegal_o
   );

   modport slave (
      input  valid_i, alu_op_i, alu_function_i,
      output ready_o, alu_operation_o, op_valid_o, mc_start_o, stall_o, illegal_o
   );
endinterface

// File: rtl/alu_control_seq.sv
// Registered ALU control decoder with MULT/DIVU sequencing: decodes ALUOp/funct
// into an ALU select and holds the front end off while the mul/div unit is busy.
module alu_control_seq #(
   parameter int OP_SEL_WIDTH  = 4,
   parameter int ENABLE_MULDIV = 1,
   parameter int MULT_CYCLES   = 4,
   parameter int DIV_CYCLES    = 32
) (
   input logic              clk,
   input logic              reset,
   alu_control_seq_if.slave bus
);
   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

   typedef enum logic {IDLE, BUSY} state_e;

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [OP_SEL_WIDTH-1:0] alu_operation_q, alu_operation_d;
   logic                    op_valid_q, op_valid_d;
   logic                    mc_start_q, mc_start_d;
   logic                    stall_q, stall_d;
   logic                    illegal_q, illegal_d;

   logic [3:0]       dec_code;
   logic             dec_illegal;
   logic             dec_multi;
   logic [CNT_W-1:0] dec_load;

   // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
   always_comb begin
      dec_code    = 4'd9;
      dec_illegal = 1'b0;
      dec_multi   = 1'b0;
      dec_load    = '0;
      unique case (bus.alu_op_i)
         3'b111: begin
            case (bus.alu_function_i)
               6'b100010: dec_code = 4'd1;
               6'b100101: dec_code = 4'd2;
               6'b100000: dec_code = 4'd3;
               6'b000000: dec_code = 4'd5;
               6'b000010: dec_code = 4'd6;
               6'b100100: dec_code = 4'd7;
               6'b100111: dec_code = 4'd8;
               6'b101010: dec_code = 4'd12;
               6'b011000: begin
                  if (ENABLE_MULDIV != 0) begin
                     dec_code  = 4'd10;
                     dec_multi = 1'b1;
                     dec_load  = MULT_LOAD;
                  end else begin
                     dec_illegal = 1'b1;
                  end
               end
               6'b011011: begin
                  if (ENABLE_MULDIV != 0) begin
                     dec_code  = 4'd11;
                     dec_multi = 1'b1;
                     dec_load  = DIV_LOAD;
                  end else begin
                     dec_illegal = 1'b1;
                  end
               end
               default: dec_illegal = 1'b1;
            endcase
         end
         // I-type ops ignore funct entirely.
         3'b100:  dec_code = 4'd3;
         3'b001:  dec_code = 4'd4;
         3'b010:  dec_code = 4'd2;
         3'b011:  dec_code = 4'd7;
         default: dec_code = 4'd9;
      endcase
   end

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      alu_operation_d = alu_operation_q;
      stall_d         = stall_q;
      op_valid_d      = 1'b0;
      mc_start_d      = 1'b0;
      illegal_d       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.valid_i) begin
               alu_operation_d = OP_SEL_WIDTH'(dec_code);
               if (dec_multi) begin
                  mc_start_d = 1'b1;
                  stall_d    = 1'b1;
                  cnt_d      = dec_load;
                  state_d    = BUSY;
               end else begin
                  op_valid_d = 1'b1;
                  illegal_d  = dec_illegal;
               end
            end
         end
         BUSY: begin
            // The BUSY->IDLE edge never accepts; ready_o is low for that whole cycle.
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               op_valid_d = 1'b1;
               stall_d    = 1'b0;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= IDLE;
         cnt_q           <= '0;
         alu_operation_q <= '0;
         op_valid_q      <= 1'b0;
         mc_start_q      <= 1'b0;
         stall_q         <= 1'b0;
         illegal_q       <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         alu_operation_q <= alu_operation_d;
         op_valid_q      <= op_valid_d;
         mc_start_q      <= mc_start_d;
         stall_q         <= stall_d;
         illegal_q       <= illegal_d;
      end
   end

   assign bus.ready_o         = (state_q == IDLE);
   assign bus.alu_operation_o = alu_operation_q;
   assign bus.op_valid_o      = op_valid_q;
   assign bus.mc_start_o      = mc_start_q;
   assign bus.stall_o         = stall_q;
   assign bus.illegal_o       = illegal_q;
endmodule
